// File: rtl/pipe_chain_hs_pkg.sv
// ============================================================================
// Module   : pipe_chain_hs_pkg
// Purpose  : Shared constants and helpers for the pipe_chain_hs register chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_chain_hs_pkg;

  localparam int MAX_DEPTH = 32;

  localparam logic [MAX_DEPTH-1:0] FLUSH_NONE = '0;
  localparam logic [MAX_DEPTH-1:0] FLUSH_ALL  = '1;

  // Occupancy width leaves headroom for DEPTH stages plus one skid entry.
  function automatic int OCC_W(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_chain_hs_if.sv
// ============================================================================
// Module   : pipe_chain_hs_if
// Purpose  : Valid/ready/data beat interface used on both sides of the chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_chain_hs_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/pipe_chain_hs_slot.sv
// ============================================================================
// Module   : pipe_chain_hs_slot
// Purpose  : One pipeline stage: valid/data registers with load, kill and hold.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_chain_hs_slot #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_stall,
  input  wire logic             i_flush,
  input  wire logic             i_adv,
  input  wire logic             i_src_vld,
  input  wire logic [WIDTH-1:0] i_src_dat,
  output logic                  o_vld,
  output logic                  o_vld_nxt,
  output logic [WIDTH-1:0]      o_dat
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;
  logic             w_vld_nxt;
  logic [WIDTH-1:0] w_dat_nxt;

  // Stall dominates flush; an empty stage always carries zero payload.
  always_comb begin
    w_vld_nxt = r_vld;
    w_dat_nxt = r_dat;
    if (!i_stall) begin
      if (i_flush) begin
        w_vld_nxt = 1'b0;
        w_dat_nxt = '0;
      end else if (i_adv) begin
        w_vld_nxt = i_src_vld;
        w_dat_nxt = i_src_vld ? i_src_dat : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      r_dat <= w_dat_nxt;
    end
  end

  assign o_vld     = r_vld;
  assign o_vld_nxt = w_vld_nxt;
  assign o_dat     = r_dat;

endmodule

`default_nettype wire

// File: rtl/pipe_chain_hs.sv
// ============================================================================
// Module   : pipe_chain_hs
// Purpose  : DEPTH-stage valid/ready register chain with stall, per-stage flush,
//            bubble collapse and occupancy count. PIPE_SKID_EN adds a skid entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_chain_hs
  import pipe_chain_hs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    stall,
  input  wire logic [DEPTH-1:0]        flush,
  pipe_chain_hs_if.slave               s_in,
  pipe_chain_hs_if.master              m_out,
  output logic [OCC_W(DEPTH)-1:0]      occupancy
);

  localparam int OW = OCC_W(DEPTH);

  logic [DEPTH-1:0] w_vld;
  logic [DEPTH-1:0] w_vld_nxt;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_src_vld;
  logic [WIDTH-1:0] w_dat     [DEPTH];
  logic [WIDTH-1:0] w_src_dat [DEPTH];
  logic             w_run;
  logic             w_skid_vld_nxt;
  logic [OW-1:0]    w_occ_nxt;
  logic [OW-1:0]    r_occ;

  // Advance ripples from the output back to the input so bubbles collapse.
  always_comb begin
    w_adv = '0;
    w_run = m_out.ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_run    = !w_vld[i] | w_run;
      w_adv[i] = w_run & !stall;
    end
  end

`ifdef PIPE_SKID_EN
  logic             r_skid_vld;
  logic [WIDTH-1:0] r_skid_dat;
  logic [WIDTH-1:0] w_skid_dat_nxt;
  logic             w_accept;

  assign s_in.ready   = !r_skid_vld & !stall;
  assign w_accept     = s_in.valid & s_in.ready;
  assign w_src_vld[0] = r_skid_vld | s_in.valid;
  assign w_src_dat[0] = r_skid_vld ? r_skid_dat : s_in.data;

  // A parked beat always goes ahead of fresh input; input only parks when stage 0 is blocked.
  always_comb begin
    w_skid_vld_nxt = r_skid_vld;
    w_skid_dat_nxt = r_skid_dat;
    if (!stall) begin
      if (flush[0] || w_adv[0]) begin
        w_skid_vld_nxt = 1'b0;
        w_skid_dat_nxt = '0;
      end else if (w_accept) begin
        w_skid_vld_nxt = 1'b1;
        w_skid_dat_nxt = s_in.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_vld <= 1'b0;
      r_skid_dat <= '0;
    end else begin
      r_skid_vld <= w_skid_vld_nxt;
      r_skid_dat <= w_skid_dat_nxt;
    end
  end
`else
  assign s_in.ready     = w_adv[0];
  assign w_src_vld[0]   = s_in.valid;
  assign w_src_dat[0]   = s_in.data;
  assign w_skid_vld_nxt = 1'b0;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g > 0) begin : g_link
      assign w_src_vld[g] = w_vld[g-1];
      assign w_src_dat[g] = w_dat[g-1];
    end

    pipe_chain_hs_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_stall   (stall),
      .i_flush   (flush[g]),
      .i_adv     (w_adv[g]),
      .i_src_vld (w_src_vld[g]),
      .i_src_dat (w_src_dat[g]),
      .o_vld     (w_vld[g]),
      .o_vld_nxt (w_vld_nxt[g]),
      .o_dat     (w_dat[g])
    );
  end

  always_comb begin
    w_occ_nxt = OW'(w_skid_vld_nxt);
    for (int i = 0; i < DEPTH; i++) begin
      w_occ_nxt = w_occ_nxt + OW'(w_vld_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_occ_nxt;
    end
  end

  assign occupancy  = r_occ;
  assign m_out.valid = w_vld[DEPTH-1] & !stall & !flush[DEPTH-1];
  assign m_out.data  = w_dat[DEPTH-1];

endmodule

`default_nettype wire

// File: tb/tb_pipe_chain_hs.sv
// ============================================================================
// Module   : tb_pipe_chain_hs
// Purpose  : Directed self-checking bench for pipe_chain_hs at DEPTH=3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_chain_hs;
  import pipe_chain_hs_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;

  logic                   clk;
  logic                   rst_n;
  logic                   stall;
  logic [DEPTH-1:0]       flush;
  logic [OCC_W(DEPTH)-1:0] occupancy;

  pipe_chain_hs_if #(.WIDTH(WIDTH)) u_in ();
  pipe_chain_hs_if #(.WIDTH(WIDTH)) u_out ();

  pipe_chain_hs #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .flush     (flush),
    .s_in      (u_in),
    .m_out     (u_out),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass;
  int          n_total;
  int          nxt;
  int          exp_acc;
  logic        acc;
  logic [31:0] got [$];
  logic [31:0] exp5 [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    exp5    = '{32'h21, 32'h22, 32'h24, 32'h25, 32'h26};
    rst_n       = 1'b0;
    stall       = 1'b0;
    flush       = FLUSH_NONE[DEPTH-1:0];
    u_in.valid  = 1'b0;
    u_in.data   = '0;
    u_out.ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(u_out.valid), 32'd0);
    chk("rst_out_data",  u_out.data, 32'd0);
    chk("rst_occ",       32'(occupancy), 32'd0);
    chk("rst_in_ready",  32'(u_in.ready), 32'd1);
    tick();

    // 1: streaming at full rate, DEPTH-cycle latency
    u_out.ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      u_in.valid = 1'b1;
      u_in.data  = 32'(k);
      #1 chk("t1_in_ready", 32'(u_in.ready), 32'd1);
      tick();
      if (k >= 3) begin
        chk("t1_out_valid", 32'(u_out.valid), 32'd1);
        chk("t1_out_data",  u_out.data, 32'(k - 2));
      end else begin
        chk("t1_out_valid_lat", 32'(u_out.valid), 32'd0);
      end
      chk("t1_occ", 32'(occupancy), (k < 3) ? 32'(k) : 32'd3);
    end
    u_in.valid = 1'b0;
    tick();
    chk("t1_drain7", u_out.data, 32'h7);
    chk("t1_occ2",   32'(occupancy), 32'd2);
    tick();
    chk("t1_drain8", u_out.data, 32'h8);
    chk("t1_occ1",   32'(occupancy), 32'd1);
    tick();
    chk("t1_empty_valid", 32'(u_out.valid), 32'd0);
    chk("t1_empty_data",  u_out.data, 32'd0);
    chk("t1_empty_occ",   32'(occupancy), 32'd0);

    // 2: fill with downstream blocked
    u_out.ready = 1'b0;
    nxt = 1;
    repeat (5) begin
      u_in.valid = 1'b1;
      u_in.data  = 32'(nxt);
      #1 acc = u_in.ready;
      tick();
      if (acc) nxt++;
    end
`ifdef PIPE_SKID_EN
    exp_acc = DEPTH + 1;
`else
    exp_acc = DEPTH;
`endif
    chk("t2_accepted",  32'(nxt - 1), 32'(exp_acc));
    chk("t2_occ",       32'(occupancy), 32'(exp_acc));
    chk("t2_in_ready",  32'(u_in.ready), 32'd0);
    chk("t2_out_valid", 32'(u_out.valid), 32'd1);
    chk("t2_out_data",  u_out.data, 32'h1);
    u_in.valid  = 1'b0;
    u_out.ready = 1'b1;
    for (int k = 1; k <= exp_acc; k++) begin
      #1 chk("t2_drain", u_out.data, 32'(k));
      tick();
    end
    chk("t2_drained", 32'(u_out.valid), 32'd0);

    // 3: bubble collapse
    u_out.ready = 1'b0;
    u_in.valid = 1'b1; u_in.data = 32'hA; tick();
    u_in.valid = 1'b0;                    tick();
    u_in.valid = 1'b1; u_in.data = 32'hB; tick();
    u_in.valid = 1'b0;                    tick();
    chk("t3_occ", 32'(occupancy), 32'd2);
    u_out.ready = 1'b1;
    #1 chk("t3_first", u_out.data, 32'hA);
    tick();
    chk("t3_second_valid", 32'(u_out.valid), 32'd1);
    chk("t3_second_data",  u_out.data, 32'hB);
    tick();
    chk("t3_empty", 32'(u_out.valid), 32'd0);

    // 4: stall overrides flush
    u_out.ready = 1'b0;
    u_in.valid = 1'b1; u_in.data = 32'h11; tick();
    u_in.data  = 32'h12; tick();
    u_in.data  = 32'h13; tick();
    stall       = 1'b1;
    flush       = FLUSH_ALL[DEPTH-1:0];
    u_in.data   = 32'h14;
    u_out.ready = 1'b1;
    #1;
    chk("t4_stall_out_valid", 32'(u_out.valid), 32'd0);
    chk("t4_stall_in_ready",  32'(u_in.ready), 32'd0);
    tick();
    tick();
    chk("t4_stall_occ",  32'(occupancy), 32'd3);
    chk("t4_stall_data", u_out.data, 32'h11);
    stall      = 1'b0;
    flush      = FLUSH_NONE[DEPTH-1:0];
    u_in.valid = 1'b0;
    #1 chk("t4_rel_valid", 32'(u_out.valid), 32'd1);
    chk("t4_rel_11", u_out.data, 32'h11);
    tick();
    chk("t4_rel_12", u_out.data, 32'h12);
    tick();
    chk("t4_rel_13", u_out.data, 32'h13);
    tick();
    chk("t4_rel_empty", 32'(u_out.valid), 32'd0);

    // 5: flush of the middle stage mid-stream
    u_out.ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 6) begin
        u_in.valid = 1'b1;
        u_in.data  = 32'h21 + 32'(c);
      end else begin
        u_in.valid = 1'b0;
      end
      flush = (c == 3) ? 3'b010 : FLUSH_NONE[DEPTH-1:0];
      #1;
      if (c == 4) chk("t5_occ", 32'(occupancy), 32'd2);
      if (u_out.valid && u_out.ready) got.push_back(u_out.data);
      tick();
    end
    flush = FLUSH_NONE[DEPTH-1:0];
    chk("t5_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t5_beat", (i < got.size()) ? got[i] : 32'hDEAD_BEEF, exp5[i]);
    end

    // 6: asynchronous reset mid-stream
    u_out.ready = 1'b0;
    u_in.valid = 1'b1; u_in.data = 32'h31; tick();
    u_in.data  = 32'h32; tick();
    u_in.data  = 32'h33; tick();
    chk("t6_pre_occ",  32'(occupancy), 32'd3);
    chk("t6_pre_data", u_out.data, 32'h31);
    u_in.valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(u_out.valid), 32'd0);
    chk("t6_rst_data",  u_out.data, 32'd0);
    chk("t6_rst_occ",   32'(occupancy), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("t6_post_valid", 32'(u_out.valid), 32'd0);
    chk("t6_post_occ",   32'(occupancy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
